// File: rtl/iq_integrate_dump.sv
// Quadrature integrate-and-dump: mixes the input sample with the LO sine/cosine pair,
// integrates each product over a window of dump_len accepted samples and dumps the I/Q sums.
module iq_integrate_dump #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_sample,
    input  logic [IN_W-1:0]  my_sine_in,
    input  logic [IN_W-1:0]  my_cosine_in,
    input  logic [7:0]       dump_len,
    output logic [ACC_W-1:0] out_i,
    output logic [ACC_W-1:0] out_q,
    output logic             out_valid
);

    localparam int P_W = 2 * IN_W;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [8:0]        win_len_q, win_len_d;
    logic [8:0]        len_s;
    logic              last_s;

    logic [IN_W-1:0]   smp_q, smp_d, cos_q, cos_d, sin_q, sin_d;
    logic              s0_valid_q, s0_valid_d, s0_last_q, s0_last_d;

    logic [P_W-1:0]    p_i_q, p_i_d, p_q_q, p_q_d;
    logic              s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;

    logic [ACC_W-1:0]  ext_i_s, ext_q_s;
    logic [ACC_W-1:0]  acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic [ACC_W-1:0]  out_i_q, out_i_d, out_q_q, out_q_d;
    logic              out_valid_q, out_valid_d;

    // Window counter: decides which accepted sample closes the current window.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        win_len_d = win_len_q;
        last_s    = 1'b0;
        len_s     = (dump_len == 8'd0) ? 9'd256 : {1'b0, dump_len};
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    win_len_d = len_s;
                    if (len_s == 9'd1) begin
                        last_s = 1'b1;
                        cnt_d  = 9'd0;
                    end else begin
                        state_d = RUN;
                        cnt_d   = 9'd1;
                    end
                end else begin
                    cnt_d = 9'd0;
                end
            end
            RUN: begin
                if (in_valid) begin
                    // win_len is frozen for the whole window; dump_len is ignored here
                    if (cnt_q + 9'd1 == win_len_q) begin
                        last_s  = 1'b1;
                        state_d = IDLE;
                        cnt_d   = 9'd0;
                    end else begin
                        cnt_d = cnt_q + 9'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 9'd0;
            end
        endcase
    end

    // Capture stage and product stage.
    always_comb begin
        smp_d      = in_sample;
        cos_d      = my_cosine_in;
        sin_d      = my_sine_in;
        s0_valid_d = in_valid;
        s0_last_d  = last_s;
        p_i_d      = $signed(smp_q) * $signed(cos_q);
        p_q_d      = $signed(smp_q) * $signed(sin_q);
        s1_valid_d = s0_valid_q;
        s1_last_d  = s0_last_q;
    end

    // Integrator: the dump cycle both publishes the final sum and clears for the next window.
    always_comb begin
        ext_i_s     = {{(ACC_W - P_W){p_i_q[P_W-1]}}, p_i_q};
        ext_q_s     = {{(ACC_W - P_W){p_q_q[P_W-1]}}, p_q_q};
        acc_i_d     = acc_i_q;
        acc_q_d     = acc_q_q;
        out_i_d     = out_i_q;
        out_q_d     = out_q_q;
        out_valid_d = 1'b0;
        if (s1_valid_q) begin
            if (s1_last_q) begin
                out_i_d     = acc_i_q + ext_i_s;
                out_q_d     = acc_q_q + ext_q_s;
                out_valid_d = 1'b1;
                acc_i_d     = {ACC_W{1'b0}};
                acc_q_d     = {ACC_W{1'b0}};
            end else begin
                acc_i_d = acc_i_q + ext_i_s;
                acc_q_d = acc_q_q + ext_q_s;
            end
        end else begin
            acc_i_d = acc_i_q;
            acc_q_d = acc_q_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 9'd0;
            win_len_q   <= 9'd0;
            smp_q       <= {IN_W{1'b0}};
            cos_q       <= {IN_W{1'b0}};
            sin_q       <= {IN_W{1'b0}};
            s0_valid_q  <= 1'b0;
            s0_last_q   <= 1'b0;
            p_i_q       <= {P_W{1'b0}};
            p_q_q       <= {P_W{1'b0}};
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            acc_i_q     <= {ACC_W{1'b0}};
            acc_q_q     <= {ACC_W{1'b0}};
            out_i_q     <= {ACC_W{1'b0}};
            out_q_q     <= {ACC_W{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            win_len_q   <= win_len_d;
            smp_q       <= smp_d;
            cos_q       <= cos_d;
            sin_q       <= sin_d;
            s0_valid_q  <= s0_valid_d;
            s0_last_q   <= s0_last_d;
            p_i_q       <= p_i_d;
            p_q_q       <= p_q_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            acc_i_q     <= acc_i_d;
            acc_q_q     <= acc_q_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_iq_integrate_dump.sv
// Self-checking bench for iq_integrate_dump: a window-level sum model checked every cycle,
// plus literal expectations for each directed scenario.
module tb_iq_integrate_dump;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_sample, my_sine_in, my_cosine_in, dump_len;
    logic [23:0] out_i, out_q;
    logic        out_valid;

    iq_integrate_dump #(.IN_W(8), .ACC_W(24)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sample(in_sample),
        .my_sine_in(my_sine_in), .my_cosine_in(my_cosine_in), .dump_len(dump_len),
        .out_i(out_i), .out_q(out_q), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: sums whole windows of accepted samples and schedules the dump two edges later.
    typedef struct { int due; longint i; longint q; } exp_t;
    exp_t   pend[$];
    int     cyc = 0;
    bit     started = 1'b0;
    int     m_cnt = 0, m_len = 0;
    longint m_si = 0, m_sq = 0;
    longint hold_i = 0, hold_q = 0;
    exp_t   e;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            started = 1'b1;
            m_cnt = 0; m_si = 0; m_sq = 0;
            pend.delete();
            hold_i = 0; hold_q = 0;
        end else if (in_valid) begin
            if (m_cnt == 0) m_len = (dump_len == 8'd0) ? 256 : int'(dump_len);
            m_si += longint'($signed(in_sample)) * longint'($signed(my_cosine_in));
            m_sq += longint'($signed(in_sample)) * longint'($signed(my_sine_in));
            m_cnt++;
            if (m_cnt == m_len) begin
                e.due = cyc + 2; e.i = m_si; e.q = m_sq;
                pend.push_back(e);
                m_si = 0; m_sq = 0; m_cnt = 0;
            end
        end
    end

    longint pulse_i[16], pulse_q[16];
    int     pulse_cnt = 0;
    logic   exp_v;

    always @(negedge clk) begin
        if (started) begin
            exp_v = (pend.size() > 0 && pend[0].due == cyc);
            if (exp_v) begin
                hold_i = pend[0].i;
                hold_q = pend[0].q;
                pend.delete(0);
            end
            check("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
            check("out_i", $signed(out_i), hold_i);
            check("out_q", $signed(out_q), hold_q);
            if (out_valid === 1'b1) begin
                if (pulse_cnt < 16) begin
                    pulse_i[pulse_cnt] = longint'($signed(out_i));
                    pulse_q[pulse_cnt] = longint'($signed(out_q));
                end
                pulse_cnt++;
            end
        end
    end

    task automatic step(input logic v, input int s, input int c, input int sn);
        in_valid     = v;
        in_sample    = 8'(s);
        my_cosine_in = 8'(c);
        my_sine_in   = 8'(sn);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_sample = 8'd0;
        my_sine_in = 8'd0; my_cosine_in = 8'd0; dump_len = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_out_i", $signed(out_i), 64'sd0);
        check("rst_out_q", $signed(out_q), 64'sd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'sd0);

        // Basic 4-sample window
        pulse_cnt = 0; dump_len = 8'd4;
        repeat (4) step(1'b1, 1, 1, 0);
        idle(5);
        check("t1_pulses", pulse_cnt, 64'sd1);
        check("t1_i", pulse_i[0], 64'sd4);
        check("t1_q", pulse_q[0], 64'sd0);

        // 256-sample worst-case magnitude
        pulse_cnt = 0; dump_len = 8'd0;
        repeat (256) step(1'b1, -128, -128, 127);
        idle(5);
        check("t2_pulses", pulse_cnt, 64'sd1);
        check("t2_i", pulse_i[0], 64'sd4194304);
        check("t2_q", pulse_q[0], -64'sd4161536);

        // Gapped samples
        pulse_cnt = 0; dump_len = 8'd3;
        step(1'b1, 10, 1, 0); idle(2);
        step(1'b1, 20, 1, 0); idle(2);
        check("t3_no_early", pulse_cnt, 64'sd0);
        step(1'b1, 30, 1, 0); idle(4);
        check("t3_pulses", pulse_cnt, 64'sd1);
        check("t3_i", pulse_i[0], 64'sd60);

        // Back-to-back windows
        pulse_cnt = 0; dump_len = 8'd2;
        for (int k = 1; k <= 4; k++) step(1'b1, k, 1, 1);
        idle(5);
        check("t4_pulses", pulse_cnt, 64'sd2);
        check("t4_i0", pulse_i[0], 64'sd3);
        check("t4_q0", pulse_q[0], 64'sd3);
        check("t4_i1", pulse_i[1], 64'sd7);
        check("t4_q1", pulse_q[1], 64'sd7);

        // dump_len change mid-window
        pulse_cnt = 0; dump_len = 8'd4;
        step(1'b1, 1, 1, 0);
        dump_len = 8'd2;
        repeat (3) step(1'b1, 1, 1, 0);
        repeat (2) step(1'b1, 3, 1, 0);
        idle(5);
        check("t5_pulses", pulse_cnt, 64'sd2);
        check("t5_i0", pulse_i[0], 64'sd4);
        check("t5_i1", pulse_i[1], 64'sd6);

        // Reset mid-window
        pulse_cnt = 0; dump_len = 8'd4;
        repeat (2) step(1'b1, 9, 1, 0);
        reset = 1'b1;
        step(1'b0, 0, 0, 0);
        reset = 1'b0;
        check("t6_rst_i", $signed(out_i), 64'sd0);
        check("t6_rst_q", $signed(out_q), 64'sd0);
        dump_len = 8'd2;
        repeat (2) step(1'b1, 5, 1, 0);
        idle(5);
        check("t6_pulses", pulse_cnt, 64'sd1);
        check("t6_i", pulse_i[0], 64'sd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
